// File: rtl/dds_table_loader_if.sv
// rtl/dds_table_loader_if.sv - control, byte stream and waveform buffer write port bundle
interface dds_table_loader_if #(
    parameter int ADDR_W = 10
);
    logic              Start;
    logic              Abort;
    logic [7:0]        Byte_Data;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic [15:0]       RAM_Data;
    logic [ADDR_W-1:0] RAM_Address;
    logic              RAM_Write;
    logic              RAM_Clk;
    logic              Busy;
    logic              Done;
    logic              Error;

    modport master (
        output Start, Abort, Byte_Data, Byte_Valid,
        input  Byte_Ready, RAM_Data, RAM_Address, RAM_Write, RAM_Clk, Busy, Done, Error
    );

    modport slave (
        input  Start, Abort, Byte_Data, Byte_Valid,
        output Byte_Ready, RAM_Data, RAM_Address, RAM_Write, RAM_Clk, Busy, Done, Error
    );
endinterface

// File: rtl/dds_table_loader.sv
// rtl/dds_table_loader.sv - byte stream to 16-bit DDS waveform table loader; optional trailer checksum via DDS_TABLE_LOADER_CHECKSUM_EN
module dds_table_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                Clk,
    input  logic                nReset,
    dds_table_loader_if.slave   bus
);
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, CHK_LO, CHK_HI, DONE} state_t;
    logic [15:0] checksum;
`else
    typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic              byte_ready;
    logic [7:0]        lo_byte;
    logic [15:0]       ram_data;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write;
    logic              busy;
    logic              done;
    logic              error;
    logic              take;

    // Byte_Ready is registered, so it already reflects the current state
    assign take = bus.Byte_Valid && byte_ready;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            byte_ready  <= 1'b0;
            lo_byte     <= 8'd0;
            ram_data    <= 16'd0;
            ram_address <= '0;
            ram_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
            checksum    <= 16'd0;
`endif
        end else if (bus.Abort && state != IDLE) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            ram_write  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Start && !bus.Abort) begin
                        state       <= LOW;
                        ram_address <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        byte_ready  <= 1'b1;
                        busy        <= 1'b1;
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
                        checksum    <= 16'd0;
`endif
                    end
                end
                LOW: begin
                    if (take) begin
                        lo_byte <= bus.Byte_Data;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (take) begin
                        ram_data   <= {bus.Byte_Data, lo_byte};
                        ram_write  <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= WRITE;
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
                        checksum   <= checksum + {bus.Byte_Data, lo_byte};
`endif
                    end
                end
                WRITE: begin
                    // Address advances only after the write cycle so it is stable while RAM_Write is high
                    ram_write   <= 1'b0;
                    ram_address <= ram_address + 1'b1;
                    if (ram_address == LAST_ADDR) begin
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
                        state      <= CHK_LO;
                        byte_ready <= 1'b1;
`else
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        state      <= LOW;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef DDS_TABLE_LOADER_CHECKSUM_EN
                CHK_LO: begin
                    if (take) begin
                        lo_byte <= bus.Byte_Data;
                        state   <= CHK_HI;
                    end
                end
                CHK_HI: begin
                    if (take) begin
                        error      <= ({bus.Byte_Data, lo_byte} != checksum);
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    ram_write  <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Byte_Ready  = byte_ready;
    assign bus.RAM_Data    = ram_data;
    assign bus.RAM_Address = ram_address;
    assign bus.RAM_Write   = ram_write;
    assign bus.RAM_Clk     = Clk;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.Error       = error;
endmodule

// File: doc/dds_table_loader.md
DDS_TABLE_LOADER -- requirements
Module: dds_table_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the table address width; table depth N = 2^ADDR_W words.
REQ-002 SHALL have nReset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have Clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have Start  input  1  single-cycle load request.
REQ-005 SHALL have Abort  input  1  synchronous load cancel.
REQ-006 SHALL have Byte_Data  input  8  incoming table byte.
REQ-007 SHALL have Byte_Valid  input  1  Byte_Data valid.
REQ-008 SHALL have Byte_Ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have RAM_Data  output  16  word to DDS waveform buffer.
REQ-010 SHALL have RAM_Address  output  ADDR_W  buffer write address.
REQ-011 SHALL have RAM_Write  output  1  buffer write enable.
REQ-012 SHALL have RAM_Clk  output  1  buffer write clock, driven directly from Clk.
REQ-013 SHALL have Busy  output  1  load in progress.
REQ-014 SHALL have Done  output  1  load finished (level).
REQ-015 SHALL have Error  output  1  load aborted or checksum mismatch (level).

Function
REQ-016 SHALL implement states IDLE, LOW, HIGH, WRITE, CHK_LO, CHK_HI, DONE.
REQ-017 SHALL, on Start in IDLE or DONE, clear RAM_Address, Done, Error and checksum, then enter LOW; Start in any other state SHALL be ignored.
REQ-018 SHALL assert Byte_Ready only in LOW, HIGH, CHK_LO, CHK_HI; a byte transfers when Byte_Valid and Byte_Ready are both high at a rising Clk edge.
REQ-019 SHALL, in LOW, latch the transferred byte as word bits [7:0] and go to HIGH; in HIGH, latch bits [15:8] and go to WRITE (little-endian words).
REQ-020 SHALL, in WRITE, drive RAM_Write high for exactly one cycle with RAM_Data and RAM_Address stable for that whole cycle.
REQ-021 SHALL, leaving WRITE, increment RAM_Address by 1; if the written address was N-1, go to CHK_LO (with checksum) or DONE (without); else go to LOW.
REQ-022 SHALL not wrap RAM_Address beyond N-1 during a load; after DONE, RAM_Address holds N-1+1 mod N = 0.
REQ-023 SHALL hold state while Byte_Valid is low; gaps of any length SHALL NOT alter written data or cause extra writes.
REQ-024 SHALL give minimum throughput of one word per 3 Clk cycles.
REQ-025 SHALL assert Busy in every state except IDLE and DONE; Done SHALL be high only in DONE.
REQ-026 SHALL, on Abort in any state other than IDLE, return to IDLE within one cycle, set Error, issue no further RAM_Write, and leave Done low; Abort in IDLE SHALL have no effect.
REQ-027 SHALL give Abort priority over Start and over a byte transfer in the same cycle.
REQ-028 SHALL keep Error set until the next accepted Start.

Reset
REQ-029 SHALL, while nReset is low, force state IDLE and Byte_Ready, RAM_Data, RAM_Address, RAM_Write, Busy, Done, Error, checksum and byte latch to 0; RAM_Clk SHALL continue to follow Clk.
REQ-030 SHALL, on reset mid-load, not issue a RAM_Write for a partially received word.

Configuration
REQ-031 SHALL use macro DDS_TABLE_LOADER_CHECKSUM_EN; when defined, SHALL accumulate a modulo-2^16 sum of all N written words, receive a little-endian 16-bit trailer in CHK_LO/CHK_HI, enter DONE, and set Error if trailer differs from the sum.
REQ-032 SHALL, when DDS_TABLE_LOADER_CHECKSUM_EN is undefined, omit CHK_LO, CHK_HI and the accumulator; DONE follows the last write and Error arises only from Abort.

Verification
REQ-033 Reset asserted mid-stream -> all outputs 0, Byte_Ready 0, no RAM_Write.
REQ-034 Start, 2048 bytes encoding word i = i (i = 0..1023), Byte_Valid held high -> exactly 1024 RAM_Write pulses, RAM[i] = i, Done = 1, Error = 0.
REQ-035 Same stream with Byte_Valid high every third cycle -> identical RAM contents, still 1024 pulses, each only after a high byte.
REQ-036 Checksum enabled: trailer = 0xFE00 (sum of 0..1023 mod 2^16) -> Error = 0; trailer 0xFE01 -> Done = 1, Error = 1.
REQ-037 Abort after 10 words -> IDLE, Error = 1, no further writes; Start then loads from address 0 with Error cleared.
REQ-038 Start pulsed while Busy at word 500 -> ignored, RAM_Address continues at 501.
